// File: rtl/instr_sequencer.sv
// Top-level instruction sequencer: fetches a 16-bit word, decodes opcode[15:12] and
// hands control to exactly one execution unit, advancing the PC once that unit reports done.
module instr_sequencer #(
  parameter int unsigned PC_W      = 8,
  parameter int unsigned NUM_UNITS = 8,
  parameter int unsigned TIMEOUT   = 15,
  parameter logic [3:0]  HALT_OP   = 4'hF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  output logic                 mem_req,
  input  logic                 mem_ack,
  input  logic [15:0]          mem_data,
  output logic [PC_W-1:0]      pc,
  output logic [15:0]          ir,
  output logic [5:0]           field_a,
  output logic [5:0]           field_b,
  output logic [NUM_UNITS-1:0] unit_start,
  input  logic [NUM_UNITS-1:0] unit_done,
  output logic                 busy,
  output logic                 halted,
  output logic                 fault
);

  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_ADVANCE,
    S_HALT
  } state_t;

  state_t                 state;
  logic [WD_W-1:0]        watchdog;
  logic [NUM_UNITS-1:0]   sel;

  // One-hot unit select for an opcode; zero for HALT_OP and for opcodes with no unit.
  function automatic logic [NUM_UNITS-1:0] op_onehot(input logic [3:0] op);
    if ((op != HALT_OP) && ({28'd0, op} < NUM_UNITS))
      op_onehot = NUM_UNITS'(1) << op;
    else
      op_onehot = '0;
  endfunction

  assign field_a = ir[11:6];
  assign field_b = ir[5:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      pc         <= '0;
      ir         <= '0;
      watchdog   <= '0;
      sel        <= '0;
      mem_req    <= 1'b0;
      unit_start <= '0;
      busy       <= 1'b0;
      halted     <= 1'b0;
      fault      <= 1'b0;
    end else begin
      unit_start <= '0;
      case (state)
        S_IDLE: begin
          if (run) begin
            state   <= S_FETCH;
            mem_req <= 1'b1;
            busy    <= 1'b1;
          end
        end
        // Start pulse is registered off the fetched word so it is high exactly during DECODE.
        S_FETCH: begin
          if (mem_ack) begin
            ir         <= mem_data;
            mem_req    <= 1'b0;
            sel        <= op_onehot(mem_data[15:12]);
            unit_start <= op_onehot(mem_data[15:12]);
            state      <= S_DECODE;
          end
        end
        S_DECODE: begin
          watchdog <= '0;
          if (sel != '0) begin
            state <= S_EXEC;
          end else begin
            state  <= S_HALT;
            busy   <= 1'b0;
            halted <= 1'b1;
            if (ir[15:12] != HALT_OP)
              fault <= 1'b1;
          end
        end
        // Only the selected unit's done is honoured; done beats the watchdog on a tie.
        S_EXEC: begin
          watchdog <= watchdog + WD_W'(1);
          if (|(unit_done & sel)) begin
            state <= S_ADVANCE;
          end else if (watchdog == WD_W'(TIMEOUT - 1)) begin
            state  <= S_HALT;
            busy   <= 1'b0;
            halted <= 1'b1;
            fault  <= 1'b1;
          end
        end
        S_ADVANCE: begin
          pc <= pc + PC_W'(1);
          if (run) begin
            state   <= S_FETCH;
            mem_req <= 1'b1;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        S_HALT: state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
